fifo_flush_mp: RTL

//  Multi-port circular FIFO with flush, for superscalar front/back ends.
//  - Accepts up to PUSH_W entries and delivers up to POP_W entries per cycle, in order.
//  - Reports binary occupancy and free-slot counts so producers can pre-allocate.
//  - Single-cycle flush empties the whole queue, e.g. on branch mispredict or exception.

---
 rtl/fifo_flush_mp_pkg.sv | 10 +
 rtl/and_or_mux.sv | 18 +
 rtl/fifo_ptr_wrap_add.sv | 22 ++
 rtl/fifo_flush_mp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fifo_flush_mp_pkg.sv
// Shared helpers for the multi-port flushable FIFO slice.
// Only width arithmetic lives here; every block derives its own widths from its parameters.
package fifo_flush_mp_pkg;

    // Width of an index into n slots, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/and_or_mux.sv
// One-hot select multiplexer built as an AND-OR tree; no priority between inputs.
module and_or_mux #(
    parameter int unsigned INPUTS = 2,
    parameter int unsigned DW     = 16
) (
    input  logic [INPUTS-1:0][DW-1:0] data,
    input  logic [INPUTS-1:0]         sel,
    output logic [DW-1:0]             dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < INPUTS; i++) begin
            dout = dout | (data[i] & {DW{sel[i]}});
        end
    end

endmodule

// File: rtl/fifo_ptr_wrap_add.sv
// Combinational (ptr + inc) mod DEPTH using a single conditional subtract.
// Assumes ptr < DEPTH and inc <= DEPTH, so the raw sum never exceeds 2*DEPTH-1.
module fifo_ptr_wrap_add
    import fifo_flush_mp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned INC_W = 2
) (
    input  logic [idx_width(DEPTH)-1:0] ptr,
    input  logic [INC_W-1:0]            inc,
    output logic [idx_width(DEPTH)-1:0] sum
);

    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned SW = ((PW > INC_W) ? PW : INC_W) + 1;

    logic [SW-1:0] raw;

    assign raw = SW'(ptr) + SW'(inc);
    assign sum = (raw >= SW'(DEPTH)) ? PW'(raw - SW'(DEPTH)) : raw[PW-1:0];

endmodule

// File: rtl/fifo_flush_mp.sv
// Multi-port circular FIFO: up to PUSH_W writes and POP_W reads per cycle, in order,
// with single-cycle flush. DEPTH need not be a power of two.
module fifo_flush_mp
    import fifo_flush_mp_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2,
    parameter int unsigned POP_W  = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PCW   = $clog2(PUSH_W + 1),
    localparam int unsigned QCW   = $clog2(POP_W + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [PUSH_W-1:0][DW-1:0]   push_data,
    input  logic [PCW-1:0]              push_cnt,
    output logic [CW-1:0]               free_slots,
    output logic [POP_W-1:0][DW-1:0]    pop_data,
    output logic [POP_W-1:0]            pop_valid,
    input  logic [QCW-1:0]              pop_cnt,
    output logic [CW-1:0]               count
);

    localparam int unsigned PW = idx_width(DEPTH);

    if (DEPTH < PUSH_W || DEPTH < POP_W) begin : g_depth_check
        $fatal(1, "fifo_flush_mp: DEPTH must be >= PUSH_W and >= POP_W");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_adv;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_adv;
    logic [CW-1:0] count_q, count_d;

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [DEPTH-1:0][DW-1:0] slot_wdata;
    logic [DEPTH-1:0]         slot_we;

    logic [PUSH_W-1:0][PW-1:0] wr_idx;
    logic [POP_W-1:0][PW-1:0]  rd_idx;

    fifo_ptr_wrap_add #(.DEPTH(DEPTH), .INC_W(PCW)) u_wr_adv (
        .ptr (wr_ptr_q),
        .inc (push_cnt),
        .sum (wr_ptr_adv)
    );

    fifo_ptr_wrap_add #(.DEPTH(DEPTH), .INC_W(QCW)) u_rd_adv (
        .ptr (rd_ptr_q),
        .inc (pop_cnt),
        .sum (rd_ptr_adv)
    );

    for (genvar j = 0; j < PUSH_W; j++) begin : g_wr_lane
        fifo_ptr_wrap_add #(.DEPTH(DEPTH), .INC_W(PW)) u_idx (
            .ptr (wr_ptr_q),
            .inc (PW'(j)),
            .sum (wr_idx[j])
        );
    end

    for (genvar i = 0; i < POP_W; i++) begin : g_rd_lane
        logic [DEPTH-1:0] sel;

        fifo_ptr_wrap_add #(.DEPTH(DEPTH), .INC_W(PW)) u_idx (
            .ptr (rd_ptr_q),
            .inc (PW'(i)),
            .sum (rd_idx[i])
        );

        always_comb begin
            sel = '0;
            for (int s = 0; s < DEPTH; s++) begin
                sel[s] = (rd_idx[i] == PW'(s));
            end
        end

        and_or_mux #(.INPUTS(DEPTH), .DW(DW)) u_mux (
            .data (mem_q),
            .sel  (sel),
            .dout (pop_data[i])
        );
    end

    // Active lanes hit distinct slots, so at most one lane matches any slot.
    always_comb begin
        slot_we    = '0;
        slot_wdata = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int j = 0; j < PUSH_W; j++) begin
                if ((PCW'(j) < push_cnt) && (wr_idx[j] == PW'(s))) begin
                    slot_we[s]    = 1'b1;
                    slot_wdata[s] = push_data[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (slot_we[s]) begin
                mem_q[s] <= slot_wdata[s];
            end
        end
    end

    always_comb begin
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_adv;
            rd_ptr_d = rd_ptr_adv;
            count_d  = count_q + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign free_slots = CW'(DEPTH) - count_q;

    always_comb begin
        pop_valid = '0;
        for (int i = 0; i < POP_W; i++) begin
            pop_valid[i] = (count_q > CW'(i));
        end
    end

    assert property (@(posedge clk) disable iff (rst) CW'(push_cnt) <= free_slots)
        else $fatal(1, "Pushing beyond free slots");
    assert property (@(posedge clk) disable iff (rst) CW'(pop_cnt) <= count_q)
        else $fatal(1, "Popping beyond occupancy");
    assert property (@(posedge clk) disable iff (rst) push_cnt <= PCW'(PUSH_W))
        else $fatal(1, "push_cnt exceeds PUSH_W");
    assert property (@(posedge clk) disable iff (rst) pop_cnt <= QCW'(POP_W))
        else $fatal(1, "pop_cnt exceeds POP_W");

endmodule
